mcu_shared_ram: RTL and testbench
=================================

// Module: mcu_shared_ram
// PURPOSE
// Main-CPU end of the 4 KB protection/sample-MCU shared RAM and its mailbox interrupts.
// - Arbitrates one RAM between two ports: the 16-bit main-CPU bus (req/ack) and the
//   8-bit MCU-side port (cs/we sampled on ce_8m).
// - Raises mcu_int when the CPU writes the mailbox byte; raises cpu_int when the MCU
//   writes the reply byte. Sits between the V30 bus decode and the MCU emulator.
// PARAMETERS
// INT_ADDR      12'hfff  MCU mailbox byte: CPU write sets mcu_int; any MCU access clears it
// CPU_INT_ADDR  12'hffe  reply byte: MCU write sets cpu_int; CPU read of its word clears it
// PORTS
// CLK_32M   in   1   system clock
// reset_n   in   1   synchronous, active-low reset
// ce_8m     in   1   MCU-port enable; period >= 4 CLK_32M
// cpu_addr  in   11  word address (byte address [11:1])
// cpu_din   in   16  CPU write data; [7:0] = even byte, [15:8] = odd byte
// cpu_be    in   2   byte enables; [0] = even, [1] = odd
// cpu_we    in   1   write qualifier for cpu_req
// cpu_req   in   1   access request; held until cpu_ack
// cpu_ack   out  1   1-cycle pulse: access done, cpu_dout valid
// cpu_dout  out  16  read data; held until next CPU read
// mcu_addr  in   12  MCU byte address
// mcu_din   in   8   MCU write data
// mcu_cs    in   1   MCU access, sampled only when ce_8m=1
// mcu_we    in   1   MCU write qualifier, sampled with mcu_cs
// mcu_dout  out  8   MCU read data; held until next MCU read
// mcu_int   out  1   mailbox flag to MCU
// cpu_int   out  1   reply flag to main CPU
// BEHAVIOUR
// Storage: two 2048x8 single-port banks (even/odd), 1-cycle registered read.
// - MCU byte: mcu_addr[0] selects bank, mcu_addr[11:1] indexes it.
// - RAM contents are not cleared by reset.
// Reset (reset_n=0 at an edge): state=IDLE, mcu_pend=0, cpu_ack=0, cpu_dout=0,
//   mcu_dout=0, mcu_int=0, cpu_int=0. Any in-flight access is aborted:
//   - no write completes unless its RAM enable already fired;
//   - no ack is issued.
// MCU capture: on ce_8m & mcu_cs, latch addr/din/we into the pending slot; set mcu_pend.
//   A new capture while mcu_pend=1 cannot occur, given the ce period rule.
// Arbiter FSM (MCU has priority when both are pending in IDLE):
//   IDLE:
//     - mcu_pend            -> drive RAM with MCU op, go MCU_DATA
//     - else cpu_req        -> drive both banks with CPU op (write gated per cpu_be),
//                              go CPU_DATA
//     - else stay
//   MCU_DATA:
//     - read: mcu_dout <= selected bank q
//     - clear mcu_pend; apply flag rules; -> IDLE
//   CPU_DATA:
//     - read: cpu_dout <= {odd q, even q}
//     - cpu_ack=1 this cycle; apply flag rules; -> CPU_GAP
//   CPU_GAP:
//     - cpu_req ignored (requester drops req after ack); -> IDLE
// Latency:
// - CPU: ack 2 clocks after acceptance in IDLE; 3 clocks minimum between accepted requests.
// - MCU worst case: a CPU op starts in the same clock as the capture.
//   - mcu_dout is still valid by the next ce_8m (4 clocks).
//   - Guaranteed only if ce_8m spacing >= 4.
// Flag rules (evaluated at the end of the op; ops are serialised, so no set/clear races):
// - CPU write, cpu_addr=INT_ADDR[11:1], cpu_be[1]=1  -> mcu_int <= 1.
// - MCU read or write at INT_ADDR                    -> mcu_int <= 0.
// - MCU write at CPU_INT_ADDR                        -> cpu_int <= 1.
// - CPU read of word CPU_INT_ADDR[11:1]              -> cpu_int <= 0.
// - CPU read of INT_ADDR word and MCU read of CPU_INT_ADDR do not affect the flags.
// Same-address collision: the op executed first is fully visible to the second
//   (write-then-read returns the new data).
// TESTING
// - Reset: hold reset_n=0 with cpu_req=1, mcu_cs=1, ce_8m=1.
//   -> all outputs 0; no ack in the 3 clocks after release unless req is still high.
// - CPU write 0x7ff, din=16'hA55A, be=2'b11; CPU read back.
//   -> mcu_int=1; MCU read 0xffe=8'h5A, 0xfff=8'hA5; mcu_int=0 after the MCU read of 0xfff.
// - MCU write 0xffe=8'h3C.
//   -> cpu_int=1; CPU read word 0x7ff returns {8'hA5,8'h3C}; cpu_int=0 after that ack.
// - Contention: cpu_req and ce_8m & mcu_cs in the same clock, MCU reading 0x000.
//   -> CPU acked at +2 clocks; mcu_dout valid before the next ce_8m (4-clock period).
// - Byte enables: write 0x123 with be=2'b01, din=16'hFFEE over 16'h1122.
//   -> read returns 16'h11EE.
// - Mid-op reset: assert reset_n=0 in CPU_DATA.
//   -> no cpu_ack; flags 0; FSM in IDLE on release.

Source files
------------

// File: rtl/mcu_shared_ram.sv
// Main-CPU end of the 4 KB shared RAM: arbitrates a 16-bit CPU port and an 8-bit MCU
// port onto two byte-wide banks and raises the mailbox interrupt flags.
module mcu_shared_ram #(
    parameter logic [11:0] INT_ADDR     = 12'hfff,
    parameter logic [11:0] CPU_INT_ADDR = 12'hffe
) (
    input  logic        CLK_32M,
    input  logic        reset_n,
    input  logic        ce_8m,
    input  logic [10:0] cpu_addr,
    input  logic [15:0] cpu_din,
    input  logic [1:0]  cpu_be,
    input  logic        cpu_we,
    input  logic        cpu_req,
    output logic        cpu_ack,
    output logic [15:0] cpu_dout,
    input  logic [11:0] mcu_addr,
    input  logic [7:0]  mcu_din,
    input  logic        mcu_cs,
    input  logic        mcu_we,
    output logic [7:0]  mcu_dout,
    output logic        mcu_int,
    output logic        cpu_int
);
    typedef enum logic [1:0] {IDLE, MCU_DATA, CPU_DATA, CPU_GAP} state_t;

    state_t      state_q;
    logic        mcu_pend_q;
    logic [11:0] mcu_addr_q;
    logic [7:0]  mcu_din_q;
    logic        mcu_we_q;
    logic [10:0] cpu_addr_q;
    logic [1:0]  cpu_be_q;
    logic        cpu_we_q;
    logic        cpu_ack_q;
    logic [15:0] cpu_dout_q;
    logic [7:0]  mcu_dout_q;
    logic        mcu_int_q;
    logic        cpu_int_q;

    logic            mcu_start_d;
    logic            cpu_start_d;
    logic [10:0]     ram_addr_d;
    logic [1:0][7:0] ram_din_d;
    logic [1:0]      ram_we_d;

    // RAM is driven only from IDLE and never while reset is asserted, so a write
    // happens exactly at the edge that accepts the op.
    always_comb begin
        mcu_start_d = 1'b0;
        cpu_start_d = 1'b0;
        ram_addr_d  = cpu_addr;
        ram_din_d   = cpu_din;
        ram_we_d    = 2'b00;
        if (reset_n && state_q == IDLE) begin
            if (mcu_pend_q) begin
                mcu_start_d = 1'b1;
                ram_addr_d  = mcu_addr_q[11:1];
                ram_din_d   = {mcu_din_q, mcu_din_q};
                ram_we_d    = {mcu_we_q & mcu_addr_q[0], mcu_we_q & ~mcu_addr_q[0]};
            end else if (cpu_req) begin
                cpu_start_d = 1'b1;
                ram_we_d    = cpu_we ? cpu_be : 2'b00;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [7:0] mem [0:2047];
            logic [7:0] rd_q;
            always_ff @(posedge CLK_32M) begin
                if (ram_we_d[gi]) begin
                    mem[ram_addr_d] <= ram_din_d[gi];
                end
                rd_q <= mem[ram_addr_d];
            end
        end
    endgenerate

    always_ff @(posedge CLK_32M) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mcu_pend_q <= 1'b0;
            cpu_ack_q  <= 1'b0;
            cpu_dout_q <= 16'h0000;
            mcu_dout_q <= 8'h00;
            mcu_int_q  <= 1'b0;
            cpu_int_q  <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            // A fresh capture outranks the clear so a back-to-back MCU request is kept.
            if (ce_8m && mcu_cs) begin
                mcu_addr_q <= mcu_addr;
                mcu_din_q  <= mcu_din;
                mcu_we_q   <= mcu_we;
                mcu_pend_q <= 1'b1;
            end else if (state_q == MCU_DATA) begin
                mcu_pend_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (mcu_start_d) begin
                        state_q <= MCU_DATA;
                    end else if (cpu_start_d) begin
                        cpu_addr_q <= cpu_addr;
                        cpu_be_q   <= cpu_be;
                        cpu_we_q   <= cpu_we;
                        state_q    <= CPU_DATA;
                    end
                end
                MCU_DATA: begin
                    if (!mcu_we_q) begin
                        mcu_dout_q <= mcu_addr_q[0] ? g_bank[1].rd_q : g_bank[0].rd_q;
                    end
                    if (mcu_addr_q == INT_ADDR) begin
                        mcu_int_q <= 1'b0;
                    end
                    if (mcu_we_q && mcu_addr_q == CPU_INT_ADDR) begin
                        cpu_int_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                CPU_DATA: begin
                    if (!cpu_we_q) begin
                        cpu_dout_q <= {g_bank[1].rd_q, g_bank[0].rd_q};
                    end
                    if (cpu_we_q && cpu_addr_q == INT_ADDR[11:1] && cpu_be_q[1]) begin
                        mcu_int_q <= 1'b1;
                    end
                    if (!cpu_we_q && cpu_addr_q == CPU_INT_ADDR[11:1]) begin
                        cpu_int_q <= 1'b0;
                    end
                    cpu_ack_q <= 1'b1;
                    state_q   <= CPU_GAP;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ack  = cpu_ack_q;
    assign cpu_dout = cpu_dout_q;
    assign mcu_dout = mcu_dout_q;
    assign mcu_int  = mcu_int_q;
    assign cpu_int  = cpu_int_q;
endmodule

// File: tb/tb_mcu_shared_ram.sv
// Scoreboard bench for mcu_shared_ram: a byte-array model of the shared RAM and its
// mailbox flags predicts each CPU ack and each MCU completion.
module tb_mcu_shared_ram;
    logic        clk = 1'b0;
    logic        reset_n, ce_8m, cpu_we, cpu_req, cpu_ack, mcu_cs, mcu_we, mcu_int, cpu_int;
    logic [10:0] cpu_addr;
    logic [15:0] cpu_din, cpu_dout;
    logic [1:0]  cpu_be;
    logic [11:0] mcu_addr;
    logic [7:0]  mcu_din, mcu_dout;

    typedef struct {
        bit          is_read;
        logic [15:0] data;
        bit          mcu_int;
        bit          cpu_int;
    } exp_t;

    exp_t       cpu_q[$];
    exp_t       mcu_q[$];
    logic [7:0] m_mem [4096];
    bit         m_mcu_int, m_cpu_int;
    bit         ce_force;
    bit         mcu_wait;
    int         ce_cnt;
    int         mcu_issued, mcu_done;
    int         checks, failures;

    mcu_shared_ram dut (
        .CLK_32M(clk), .reset_n(reset_n), .ce_8m(ce_8m),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_be(cpu_be), .cpu_we(cpu_we),
        .cpu_req(cpu_req), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .mcu_addr(mcu_addr), .mcu_din(mcu_din), .mcu_cs(mcu_cs), .mcu_we(mcu_we),
        .mcu_dout(mcu_dout), .mcu_int(mcu_int), .cpu_int(cpu_int)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ce_8m: one clock in four, forced high while the reset test holds it
    initial begin
        ce_8m  = 1'b0;
        ce_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            ce_cnt++;
            ce_8m = ((ce_cnt % 4) == 0) || ce_force;
        end
    end

    // CPU monitor: every ack must match the oldest outstanding CPU expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    chk("cpu_ack_unexpected", 16'd1, 16'd0);
                end else begin
                    e = cpu_q.pop_front();
                    if (e.is_read) chk("cpu_dout", cpu_dout, e.data);
                    chk("cpu_ack_mcu_int", 16'(mcu_int), 16'(e.mcu_int));
                    chk("cpu_ack_cpu_int", 16'(cpu_int), 16'(e.cpu_int));
                end
                $display("CPU ack: dout=%h mcu_int=%0d cpu_int=%0d", cpu_dout, mcu_int, cpu_int);
            end
        end
    end

    // MCU monitor: an MCU op's result must be in place by the next ce_8m after capture
    initial begin
        exp_t e;
        bit   cap;
        mcu_wait = 1'b0;
        mcu_done = 0;
        forever begin
            @(posedge clk);
            cap = reset_n && ce_8m && mcu_cs;
            if (mcu_wait && ce_8m) begin
                #1;
                if (mcu_q.size() == 0) begin
                    chk("mcu_q_underflow", 16'd1, 16'd0);
                end else begin
                    e = mcu_q.pop_front();
                    if (e.is_read) chk("mcu_dout", {8'h00, mcu_dout}, e.data);
                    chk("mcu_done_mcu_int", 16'(mcu_int), 16'(e.mcu_int));
                    chk("mcu_done_cpu_int", 16'(cpu_int), 16'(e.cpu_int));
                end
                $display("MCU done: dout=%h mcu_int=%0d cpu_int=%0d", mcu_dout, mcu_int, cpu_int);
                mcu_done++;
                mcu_wait = 1'b0;
            end
            if (cap) mcu_wait = 1'b1;
        end
    end

    task automatic cpu_op(input bit we, input logic [10:0] addr, input logic [1:0] be,
                          input logic [15:0] din);
        exp_t e;
        int   n;
        e.is_read = !we;
        e.data    = 16'h0000;
        if (we) begin
            if (be[0]) m_mem[{addr, 1'b0}] = din[7:0];
            if (be[1]) m_mem[{addr, 1'b1}] = din[15:8];
            if (addr == 11'h7ff && be[1]) m_mcu_int = 1'b1;
        end else begin
            e.data = {m_mem[{addr, 1'b1}], m_mem[{addr, 1'b0}]};
            if (addr == 11'h7ff) m_cpu_int = 1'b0;
        end
        e.mcu_int = m_mcu_int;
        e.cpu_int = m_cpu_int;
        cpu_q.push_back(e);
        cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_din = din; cpu_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!cpu_ack && n < 20);
        cpu_req = 1'b0;
        chk("cpu_ack_latency", 16'(n), 16'd2);
        if (!cpu_ack) void'(cpu_q.pop_back());
        tick();
    endtask

    task automatic mcu_op(input bit we, input logic [11:0] addr, input logic [7:0] din);
        exp_t e;
        int   n;
        while (!ce_8m) tick();
        e.is_read = !we;
        e.data    = {8'h00, m_mem[addr]};
        if (we) begin
            m_mem[addr] = din;
            if (addr == 12'hffe) m_cpu_int = 1'b1;
        end
        if (addr == 12'hfff) m_mcu_int = 1'b0;
        e.mcu_int = m_mcu_int;
        e.cpu_int = m_cpu_int;
        mcu_q.push_back(e);
        mcu_we = we; mcu_addr = addr; mcu_din = din; mcu_cs = 1'b1;
        tick();
        mcu_cs = 1'b0;
        mcu_issued++;
        n = 0;
        while (mcu_done != mcu_issued && n < 20) begin
            tick();
            n++;
        end
        if (mcu_done != mcu_issued) chk("mcu_completion_timeout", 16'(mcu_done), 16'(mcu_issued));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] w;
        mcu_issued = 0; checks = 0; failures = 0;
        m_mcu_int = 1'b0; m_cpu_int = 1'b0;
        reset_n = 1'b0; ce_force = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h7ff; cpu_be = 2'b11; cpu_din = 16'hFFFF;
        mcu_cs = 1'b1; mcu_we = 1'b1; mcu_addr = 12'hffe; mcu_din = 8'hFF;

        // reset held with requests active
        repeat (4) tick();
        chk("rst_cpu_ack", 16'(cpu_ack), 16'd0);
        chk("rst_cpu_dout", cpu_dout, 16'h0000);
        chk("rst_mcu_dout", {8'h00, mcu_dout}, 16'h0000);
        chk("rst_mcu_int", 16'(mcu_int), 16'd0);
        chk("rst_cpu_int", 16'(cpu_int), 16'd0);
        reset_n = 1'b1; cpu_req = 1'b0; mcu_cs = 1'b0; ce_force = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_ack", 16'(cpu_ack), 16'd0);
        end

        // mailbox handshake
        cpu_op(1'b1, 11'h7ff, 2'b11, 16'hA55A);
        cpu_op(1'b0, 11'h7ff, 2'b11, 16'h0000);
        mcu_op(1'b0, 12'hffe, 8'h00);
        mcu_op(1'b0, 12'hfff, 8'h00);
        mcu_op(1'b1, 12'hffe, 8'h3C);
        cpu_op(1'b0, 11'h7ff, 2'b11, 16'h0000);

        // byte enables
        cpu_op(1'b1, 11'h123, 2'b11, 16'h1122);
        cpu_op(1'b1, 11'h123, 2'b01, 16'hFFEE);
        cpu_op(1'b0, 11'h123, 2'b11, 16'h0000);

        for (int i = 0; i < 16; i++) cpu_op(1'b1, 11'(i), 2'b11, 16'($urandom));

        // contention: CPU request and MCU capture in the same clock
        while (!ce_8m) tick();
        fork
            cpu_op(1'b0, 11'h005, 2'b11, 16'h0000);
            mcu_op(1'b0, 12'h000, 8'h00);
        join

        // mid-op reset while the CPU op is in its data phase
        cpu_op(1'b1, 11'h7ff, 2'b10, 16'h7700);
        mcu_op(1'b1, 12'hffe, 8'h44);
        cpu_op(1'b0, 11'h006, 2'b11, 16'h0000);
        cpu_we = 1'b1; cpu_addr = 11'h400; cpu_be = 2'b11; cpu_din = 16'hBEEF; cpu_req = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        chk("midrst_ack", 16'(cpu_ack), 16'd0);
        cpu_req = 1'b0;
        tick();
        reset_n = 1'b1;
        m_mem[12'h800] = 8'hEF;
        m_mem[12'h801] = 8'hBE;
        m_mcu_int = 1'b0;
        m_cpu_int = 1'b0;
        chk("midrst_mcu_int", 16'(mcu_int), 16'd0);
        chk("midrst_cpu_int", 16'(cpu_int), 16'd0);
        chk("midrst_cpu_dout", cpu_dout, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_no_ack", 16'(cpu_ack), 16'd0);
        end
        cpu_op(1'b0, 11'h400, 2'b11, 16'h0000);

        // randomized serial traffic
        for (int i = 0; i < 80; i++) begin
            w = ($urandom_range(0, 7) == 0) ? 11'h7ff : 11'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0)
                cpu_op(1'($urandom_range(0, 1)), w, 2'($urandom_range(0, 3)), 16'($urandom));
            else
                mcu_op(1'($urandom_range(0, 1)), {w, 1'($urandom_range(0, 1))}, 8'($urandom));
        end

        repeat (8) tick();
        chk("cpu_q_drained", 16'(cpu_q.size()), 16'd0);
        chk("mcu_q_drained", 16'(mcu_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
